// File: rtl/exec_ctrl.sv
// Execute-stage controller: accepts one decoded instruction, steers the external ALU,
// maintains the condition codes and presents valE/cnd through a valid/ready result port.
module exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [1:0]  alu_fn,
  input  logic [63:0] alu_result,
  input  logic        alu_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] valE,
  output logic        cnd,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_e;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_LEAVE  = 4'hC;

  localparam logic [63:0] STACK_UP   = 64'd8;
  localparam logic [63:0] STACK_DOWN = 64'hFFFF_FFFF_FFFF_FFF8;

  function automatic logic cond_eval(input logic [3:0] fn, input logic z, input logic s,
                                     input logic o);
    logic r;
    case (fn)
      4'h0:    r = 1'b1;
      4'h1:    r = (s ^ o) | z;
      4'h2:    r = s ^ o;
      4'h3:    r = z;
      4'h4:    r = ~z;
      4'h5:    r = ~(s ^ o);
      4'h6:    r = ~(s ^ o) & ~z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d;
  logic [63:0] vala_q, vala_d, valb_q, valb_d, valc_q, valc_d;
  logic [63:0] vale_q, vale_d;
  logic        cnd_q, cnd_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic        halted_q, halted_d, err_q, err_d;
  logic        in_ready_q, out_valid_q;
  logic        illegal_s;

  // ALU operand steering, only live while an instruction is executing
  always_comb begin
    alu_a  = 64'd0;
    alu_b  = 64'd0;
    alu_fn = 2'd0;
    if (state_q == EXEC) begin
      case (icode_q)
        I_RRMOVQ:                   alu_a = vala_q;
        I_OPQ:                      alu_a = vala_q;
        I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valc_q;
        I_CALL, I_PUSHQ:            alu_a = STACK_DOWN;
        I_RET, I_POPQ, I_LEAVE:     alu_a = STACK_UP;
        default:                    alu_a = 64'd0;
      endcase
      case (icode_q)
        I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valb_q;
        I_LEAVE:                                                  alu_b = vala_q;
        default:                                                  alu_b = 64'd0;
      endcase
      alu_fn = (icode_q == I_OPQ) ? ifun_q[1:0] : 2'd0;
    end else begin
      alu_a  = 64'd0;
      alu_b  = 64'd0;
      alu_fn = 2'd0;
    end
  end

  assign illegal_s = (icode > I_LEAVE) || ((icode == I_OPQ) && (ifun > 4'd3));

  // Next-state, operand latch, result and condition-code update
  always_comb begin
    state_d  = state_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    vala_d   = vala_q;
    valb_d   = valb_q;
    valc_d   = valc_q;
    vale_d   = vale_q;
    cnd_d    = cnd_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;
    halted_d = halted_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (icode == I_HALT) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else if (illegal_s) begin
            err_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            icode_d = icode;
            ifun_d  = ifun;
            vala_d  = valA;
            valb_d  = valB;
            valc_d  = valC;
            state_d = EXEC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        vale_d = (icode_q == I_NOP) ? 64'd0 : alu_result;
        // cnd uses the CC as it stood before this instruction
        if ((icode_q == I_JXX) || (icode_q == I_RRMOVQ)) begin
          cnd_d = cond_eval(ifun_q, zf_q, sf_q, of_q);
        end else begin
          cnd_d = 1'b0;
        end
        if (icode_q == I_OPQ) begin
          zf_d = (alu_result == 64'd0);
          sf_d = alu_result[63];
          of_d = alu_ovf;
        end else begin
          zf_d = zf_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; handshake flags are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      icode_q     <= 4'd0;
      ifun_q      <= 4'd0;
      vala_q      <= 64'd0;
      valb_q      <= 64'd0;
      valc_q      <= 64'd0;
      vale_q      <= 64'd0;
      cnd_q       <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      vala_q      <= vala_d;
      valb_q      <= valb_d;
      valc_q      <= valc_d;
      vale_q      <= vale_d;
      cnd_q       <= cnd_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign valE      = vale_q;
  assign cnd       = cnd_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: a behavioural ALU, a table of instructions with
// hand-computed results, and hand-written backpressure/throughput/reset/halt sequences.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic [63:0] alu_a, alu_b;
  logic [1:0]  alu_fn;
  logic [63:0] alu_result;
  logic        alu_ovf;
  logic        out_valid, out_ready;
  logic [63:0] valE;
  logic        cnd, zf, sf, of, halted, err;

  int checks = 0;
  int errors = 0;

  exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
    .alu_result(alu_result), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .valE(valE), .cnd(cnd),
    .zf(zf), .sf(sf), .of(of), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // External ALU: add, b-a, and, xor with signed overflow
  always_comb begin
    alu_result = 64'd0;
    alu_ovf    = 1'b0;
    case (alu_fn)
      2'd0: begin
        alu_result = alu_a + alu_b;
        alu_ovf    = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      2'd1: begin
        alu_result = alu_b - alu_a;
        alu_ovf    = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_b[63]);
      end
      2'd2:    alu_result = alu_a & alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [63:0] a, b, c;
    logic [63:0] ea, eb;
    logic [1:0]  efn;
    logic [63:0] ev;
    logic        ec, ez, es, eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [63:0] ea,
                         input logic [63:0] eb, input logic [1:0] efn, input logic [63:0] ev,
                         input logic ec, input logic ez, input logic es, input logic eo);
    vec_t v;
    v.ic = ic; v.fn = fn; v.a = a; v.b = b; v.c = c; v.ea = ea; v.eb = eb; v.efn = efn;
    v.ev = ev; v.ec = ec; v.ez = ez; v.es = es; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; in_valid = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_valE"}, valE, 64'd0);
    chk({tag, "_cnd"}, {63'd0, cnd}, 64'd0);
    chk({tag, "_cc"}, {61'd0, zf, sf, of}, 64'd4);
    chk({tag, "_halted"}, {63'd0, halted}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_alu_a"}, alu_a, 64'd0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    wait_idle();
    drive(v.ic, v.fn, v.a, v.b, v.c);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({p, "_exec_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({p, "_alu_a"}, alu_a, v.ea);
    chk({p, "_alu_b"}, alu_b, v.eb);
    chk({p, "_alu_fn"}, {62'd0, alu_fn}, {62'd0, v.efn});
    @(posedge clk);
    @(negedge clk);
    chk({p, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({p, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({p, "_valE"}, valE, v.ev);
    chk({p, "_cnd"}, {63'd0, cnd}, {63'd0, v.ec});
    chk({p, "_cc"}, {61'd0, zf, sf, of}, {61'd0, v.ez, v.es, v.eo});
    chk({p, "_alu_a_done"}, alu_a, 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({p, "_back_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  task automatic halt_case(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                           input logic exp_err);
    wait_idle();
    drive(ic, fn, 64'd1, 64'd2, 64'd3);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_halted"}, {63'd0, halted}, 64'd1);
    chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
    drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_hold"}, {61'd0, in_ready, out_valid, halted}, 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals({tag, "_rst"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    icode = 4'h0; ifun = 4'h0; valA = 64'd0; valB = 64'd0; valC = 64'd0;

    //      ic    fn    valA                    valB                    valC    alu_a                   alu_b                   fn    valE                    c     z     s     o
    add_vec(4'h6, 4'h1, 64'd5,                  64'd5,                  64'd0,  64'd5,                  64'd5,                  2'd1, 64'd0,                  1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 64'd0,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 2'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec(4'h6, 4'h1, 64'd5,                  64'd3,                  64'd0,  64'd5,                  64'd3,                  2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(4'h7, 4'h2, 64'h11,                 64'h22,                 64'h33, 64'd0,                  64'd0,                  2'd0, 64'd0,                  1'b1, 1'b0, 1'b1, 1'b0);
    add_vec(4'h7, 4'h1, 64'h11,                 64'h22,                 64'h33, 64'd0,                  64'd0,                  2'd0, 64'd0,                  1'b1, 1'b0, 1'b1, 1'b0);
    add_vec(4'h7, 4'h6, 64'h11,                 64'h22,                 64'h33, 64'd0,                  64'd0,                  2'd0, 64'd0,                  1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(4'h2, 4'h4, 64'h1234,               64'h77,                 64'd0,  64'h1234,               64'd0,                  2'd0, 64'h1234,               1'b1, 1'b0, 1'b1, 1'b0);
    add_vec(4'hA, 4'h0, 64'h55,                 64'h100,                64'd0,  64'hFFFF_FFFF_FFFF_FFF8, 64'h100,               2'd0, 64'hF8,                 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(4'h6, 4'h2, 64'hF0,                 64'h0F,                 64'd0,  64'hF0,                 64'h0F,                 2'd2, 64'd0,                  1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(4'h7, 4'h3, 64'd0,                  64'd0,                  64'd0,  64'd0,                  64'd0,                  2'd0, 64'd0,                  1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(4'h7, 4'h0, 64'd0,                  64'd0,                  64'd0,  64'd0,                  64'd0,                  2'd0, 64'd0,                  1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(4'h6, 4'h3, 64'hFF,                 64'h0F,                 64'd0,  64'hFF,                 64'h0F,                 2'd3, 64'hF0,                 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'h7, 4'h5, 64'd0,                  64'd0,                  64'd0,  64'd0,                  64'd0,                  2'd0, 64'd0,                  1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(4'h1, 4'h0, 64'h66,                 64'h77,                 64'h88, 64'd0,                  64'd0,                  2'd0, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'h3, 4'h0, 64'h66,                 64'h77,                 64'h55, 64'h55,                 64'd0,                  2'd0, 64'h55,                 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'h5, 4'h0, 64'h66,                 64'h20,                 64'h10, 64'h10,                 64'h20,                 2'd0, 64'h30,                 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'h9, 4'h0, 64'h66,                 64'h200,                64'd0,  64'd8,                  64'h200,                2'd0, 64'h208,                1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'hC, 4'h0, 64'h300,                64'h999,                64'd0,  64'd8,                  64'h300,                2'd0, 64'h308,                1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'h8, 4'h0, 64'h66,                 64'h1000,               64'd0,  64'hFFFF_FFFF_FFFF_FFF8, 64'h1000,              2'd0, 64'hFF8,                1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'hB, 4'h0, 64'h66,                 64'h40,                 64'd0,  64'd8,                  64'h40,                 2'd0, 64'h48,                 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'h4, 4'h0, 64'h66,                 64'd8,                  64'd8,  64'd8,                  64'd8,                  2'd0, 64'h10,                 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'h2, 4'h7, 64'd3,                  64'h77,                 64'd0,  64'd3,                  64'd0,                  2'd0, 64'd3,                  1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(4'h7, 4'h4, 64'd0,                  64'd0,                  64'd0,  64'd0,                  64'd0,                  2'd0, 64'd0,                  1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(4'h7, 4'h8, 64'd0,                  64'd0,                  64'd0,  64'd0,                  64'd0,                  2'd0, 64'd0,                  1'b0, 1'b0, 1'b0, 1'b0);

    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Backpressure: result must hold while out_ready stays low
    wait_idle();
    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_alu_a", alu_a, 64'hFFFF_FFFF_FFFF_FFF8);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_valE", valE, 64'hF8);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    chk("bp_cc", {61'd0, zf, sf, of}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released", {62'd0, in_ready, out_valid}, 64'd2);

    // Throughput: one instruction every 3 cycles with both sides always ready
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("tp%0d_in_ready", k), {63'd0, in_ready}, {63'd0, (k % 3) == 0});
      chk($sformatf("tp%0d_out_valid", k), {63'd0, out_valid}, {63'd0, (k % 3) == 2});
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset while an OPq is executing; CC is zf=0 beforehand
    wait_idle();
    chk("pre_abort_cc", {61'd0, zf, sf, of}, 64'd0);
    drive(4'h6, 4'h1, 64'd5, 64'd3, 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_alu_fn", {62'd0, alu_fn}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_cc", {61'd0, zf, sf, of}, 64'd4);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("abort_after");

    halt_case("halt", 4'h0, 4'h0, 1'b0);
    halt_case("bad_f", 4'hF, 4'h0, 1'b1);
    halt_case("bad_d", 4'hD, 4'h0, 1'b1);
    halt_case("bad_op", 4'h6, 4'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
